dither_quantizer: RTL
=====================

# dither_quantizer

Parametrised multi-channel colour quantiser for the VGA display path. It sits between the pixel source (serial frame buffer / colour generator) and the VGA DAC pins. Each of N_CH channels is reduced from IN_BITS to OUT_BITS using one of four run-time modes: truncate, round, 1-D horizontal error diffusion, or 2x2 ordered (Bayer) dither. Output is registered and aligned with a delayed `visible` flag.

## Interface
- IN_BITS, 8, input bits per channel
- OUT_BITS, 4, output bits per channel; D = IN_BITS-OUT_BITS must be >= 2
- N_CH, 3, channel count (channel 0 at LSBs of packed buses)

- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  00 truncate, 01 round, 10 error diffusion, 11 Bayer 2x2
- visible  in  1  pixel at color_in is in the active area
- frame_start  in  1  one-cycle pulse in blanking before first line; clears line parity
- color_in  in  N_CH*IN_BITS  packed input pixel
- color_out  out  N_CH*OUT_BITS  packed quantised pixel, registered
- visible_out  out  1  visible delayed one cycle

## Operation
- Per channel, with x = channel input and MAX = 2^IN_BITS-1:
  - truncate: q = x >> D.
  - round: s = x + 2^(D-1); q = (s > MAX) ? 2^OUT_BITS-1 : s >> D.
  - diffusion: s = x + err (err is D bits); if s > MAX, q = all ones and err_next = 0; else q = s >> D and err_next = s[D-1:0].
  - Bayer: bias = M * 2^(D-2), with M = {0,2,3,1} indexed by {line_par,pix_par} = 00,01,10,11; s = x + bias; saturate as in round.
- Internal sums are IN_BITS+1 wide. No wrap-around is permitted; saturation always applies.
- err register per channel:
  - Updates only when visible=1 and mode=10.
  - Cleared to 0 when visible=0, when mode≠10, or on rst.
  - Each line therefore starts with zero error.
- pix_par toggles every cycle with visible=1 and is cleared when visible=0.
- line_par toggles on each falling edge of visible (registered visible=1, current visible=0). It is cleared on frame_start or rst. If frame_start and the falling edge occur together, frame_start wins.
- When visible=0, color_out is forced to 0 (blanking) on the next cycle, regardless of mode.
- A mode change takes effect on the next clock. Error is discarded when leaving diffusion mode, and diffusion restarts from err=0.

## Timing
- Latency is exactly 1 cycle: color_in/visible/mode sampled at edge k, result appears on color_out/visible_out after edge k.
- Reset values: color_out=0, visible_out=0, all err=0, pix_par=0, line_par=0.
- rst mid-line: outputs are 0 the cycle after rst. The first pixel after rst deasserts uses err=0 and pix_par=0.
- No handshake; the block accepts one pixel per clock continuously.

## Structure
- Package dither_pkg holds:
  - typedef enum logic [1:0] dither_mode_t {DITH_TRUNC, DITH_ROUND, DITH_DIFFUSE, DITH_BAYER};
  - the 4-entry BAYER2 matrix constant.
- Sub-module dither_channel: one channel's quantiser plus its err register, instantiated N_CH times via generate.
- Top level owns pix_par, line_par, the visible delay register and the output register.

## Test plan
All scenarios use IN=8, OUT=4, N_CH=3 and the same value on all channels unless stated.
- Truncate: mode=00, visible=1, in=0x47 -> out=0x4 after 1 cycle; visible_out=1.
- Round:
  - in=0x48 -> 0x5; in=0x47 -> 0x4.
  - in=0xFC -> 0xF (saturated, no wrap to 0x0).
- Diffusion, constant 0x48 for 6 visible cycles -> 4,5,4,5,4,5. Drop visible one cycle (out=0), then 0x48 -> 4 (err cleared).
- Diffusion overflow, constant 0xFF -> F,F,F. Internal err is F then 0, with no wrap.
- Bayer with in=0x46:
  - line 0 -> 4,4 alternating.
  - after a visible falling edge, line 1 -> 5,4.
  - after frame_start, line parity returns to line 0 pattern.
- Reset mid-line, diffusion with err=8 pending: assert rst one cycle -> color_out=0, visible_out=0. Next 0x48 pixel -> 4.

Source files
------------

// File: rtl/dither_pkg.sv
`default_nettype none
// ============================================================================
// dither_pkg : shared mode encoding and 2x2 Bayer threshold matrix
// Revision   : 1.0
// ============================================================================
package dither_pkg;

  typedef enum logic [1:0] {
    DITH_TRUNC   = 2'b00,
    DITH_ROUND   = 2'b01,
    DITH_DIFFUSE = 2'b10,
    DITH_BAYER   = 2'b11
  } dither_mode_t;

  // Indexed by {line_par, pix_par}
  localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

endpackage
`default_nettype wire

// File: rtl/dither_channel.sv
`default_nettype none
// ============================================================================
// dither_channel : single-channel quantiser with its diffusion error register
// Revision       : 1.0
// ============================================================================
module dither_channel
  import dither_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  dither_mode_t        mode_i,
  input  logic                visible_i,
  input  logic                line_par_i,
  input  logic                pix_par_i,
  input  logic [IN_BITS-1:0]  x_i,
  output logic [OUT_BITS-1:0] q_o
);

  localparam int D  = IN_BITS - OUT_BITS;
  localparam int SW = IN_BITS + 1;

  logic [D-1:0]  err_q, err_d;
  logic [SW-1:0] addend;
  logic [SW-1:0] sum;
  logic          sat;

  always_comb begin
    addend = '0;
    case (mode_i)
      DITH_TRUNC:   addend = '0;
      DITH_ROUND:   addend = SW'(1) << (D - 1);
      DITH_DIFFUSE: addend = SW'(err_q);
      DITH_BAYER:   addend = SW'(BAYER2[{line_par_i, pix_par_i}]) << (D - 2);
      default:      addend = '0;
    endcase
    sum = {1'b0, x_i} + addend;
    // Carry into the extra bit means the sum exceeded full scale
    sat = sum[IN_BITS];
    q_o = sat ? '1 : sum[IN_BITS-1:D];

    err_d = '0;
    if (visible_i && (mode_i == DITH_DIFFUSE) && !sat) begin
      err_d = sum[D-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dither_quantizer.sv
`default_nettype none
// ============================================================================
// dither_quantizer : N-channel colour quantiser with pixel/line parity tracking
// Revision         : 1.0
// ============================================================================
module dither_quantizer
  import dither_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4,
  parameter int N_CH     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     visible,
  input  logic                     frame_start,
  input  logic [N_CH*IN_BITS-1:0]  color_in,
  output logic [N_CH*OUT_BITS-1:0] color_out,
  output logic                     visible_out
);

  dither_mode_t              mode_e;
  logic                      visible_q;
  logic                      pix_par_q, pix_par_d;
  logic                      line_par_q, line_par_d;
  logic [N_CH*OUT_BITS-1:0]  color_q, color_d;
  logic [N_CH*OUT_BITS-1:0]  q_all;

  assign mode_e = dither_mode_t'(mode);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dither_channel #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .mode_i     (mode_e),
      .visible_i  (visible),
      .line_par_i (line_par_q),
      .pix_par_i  (pix_par_q),
      .x_i        (color_in[i*IN_BITS +: IN_BITS]),
      .q_o        (q_all[i*OUT_BITS +: OUT_BITS])
    );
  end

  always_comb begin
    pix_par_d  = visible ? ~pix_par_q : 1'b0;
    line_par_d = line_par_q;
    // frame_start takes priority over a coincident end-of-line
    if (frame_start) begin
      line_par_d = 1'b0;
    end else if (visible_q && !visible) begin
      line_par_d = ~line_par_q;
    end
    color_d = visible ? q_all : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      visible_q  <= 1'b0;
      pix_par_q  <= 1'b0;
      line_par_q <= 1'b0;
      color_q    <= '0;
    end else begin
      visible_q  <= visible;
      pix_par_q  <= pix_par_d;
      line_par_q <= line_par_d;
      color_q    <= color_d;
    end
  end

  assign color_out   = color_q;
  assign visible_out = visible_q;

endmodule
`default_nettype wire
